// File: rtl/wb_commit_monitor_pkg.sv
// Shared types and constants for the writeback commit monitor:
// the commit-record layout, halt-cause encodings and FSM states.
package wb_commit_monitor_pkg;

  localparam logic [31:0] JAL_SELF_LOOP = 32'h0000_006f;

  typedef enum logic [1:0] {
    CAUSE_NONE      = 2'b00,
    CAUSE_END_PC    = 2'b01,
    CAUSE_SELF_LOOP = 2'b10,
    CAUSE_WATCHDOG  = 2'b11
  } halt_cause_e;

  typedef enum logic [1:0] {
    ST_RUN,
    ST_DRAIN,
    ST_DONE
  } state_e;

  typedef struct packed {
    logic [31:0] pc;
    logic [4:0]  rd;
    logic [31:0] wdata;
  } commit_rec_t;

  // Records without a real register write carry rd=0 and wdata=0.
  function automatic commit_rec_t make_record(input logic [31:0] pc,
                                              input logic        regwrite,
                                              input logic [4:0]  rd,
                                              input logic [31:0] wdata);
    commit_rec_t rec;
    rec.pc    = pc;
    rec.rd    = (regwrite && rd != 5'd0) ? rd : 5'd0;
    rec.wdata = (regwrite && rd != 5'd0) ? wdata : 32'd0;
    return rec;
  endfunction

endpackage

// File: rtl/wb_commit_monitor_fifo.sv
// Synchronous FIFO with a registered head word; a push into an empty (or
// emptying) FIFO is forwarded straight into the head register.
module commit_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 69
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head,
  output logic                     empty,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    rd_ptr_nxt;
  logic [AW:0]      count_nxt;
  logic             do_push;
  logic             do_pop;

  assign empty      = (count == '0);
  assign full       = (count == (AW+1)'(DEPTH));
  assign do_pop     = pop && !empty;
  assign do_push    = push && (!full || do_pop);
  assign rd_ptr_nxt = do_pop ? rd_ptr + 1'b1 : rd_ptr;
  assign count_nxt  = count + (AW+1)'(do_push) - (AW+1)'(do_pop);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk) begin
    if (rstn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      head   <= '0;
    end else begin
      count  <= count_nxt;
      rd_ptr <= rd_ptr_nxt;
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (count_nxt == '0)
        head <= '0;
      else if (do_push && wr_ptr == rd_ptr_nxt)
        head <= push_data;
      else
        head <= mem[rd_ptr_nxt];
    end
  end

  // NOTE: storage is deliberately not reset; occupancy and the head register
  // decide what is visible, so stale slots are never observed.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/wb_commit_monitor.sv
// Retirement monitor: counts cycles and retirements, buffers commit records
// for a trace sink, and raises halted once the program ends and trace drains.
module wb_commit_monitor
  import wb_commit_monitor_pkg::*;
#(
  parameter logic [31:0] END_PC     = 32'h0000_0050,
  parameter int unsigned MAX_CYCLES = 40,
  parameter int unsigned FIFO_DEPTH = 8
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        wb_valid,
  input  logic [31:0] wb_pc,
  input  logic [31:0] wb_instr,
  input  logic        wb_regwrite,
  input  logic [4:0]  wb_rd,
  input  logic [31:0] wb_wdata,
  output logic        trace_valid,
  input  logic        trace_ready,
  output logic [31:0] trace_pc,
  output logic [4:0]  trace_rd,
  output logic [31:0] trace_wdata,
  output logic [31:0] retired_cnt,
  output logic [31:0] cycle_cnt,
  output logic        halted,
  output logic [1:0]  halt_cause,
  output logic        overflow
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  state_e      state;
  commit_rec_t rec;
  commit_rec_t head;
  logic        fifo_empty;
  logic        fifo_full;
  logic [CW-1:0] fifo_count;
  logic        push;
  logic        pop;
  logic        trigger;
  logic        drain_done;
  halt_cause_e cause_nxt;

  assign rec         = make_record(wb_pc, wb_regwrite, wb_rd, wb_wdata);
  assign push        = (state == ST_RUN) && wb_valid;
  assign trace_valid = !fifo_empty;
  assign pop         = trace_valid && trace_ready;
  // Look one edge ahead so halted can rise right after the last pop.
  assign drain_done  = fifo_empty || (pop && fifo_count == CW'(1));

  // NOTE: every output of a combinational block gets a default first,
  // otherwise an uncovered path infers a latch.
  always_comb begin
    cause_nxt = CAUSE_NONE;
    trigger   = 1'b1;
    if (wb_valid && wb_pc == END_PC)
      cause_nxt = CAUSE_END_PC;
    else if (wb_valid && wb_instr == JAL_SELF_LOOP)
      cause_nxt = CAUSE_SELF_LOOP;
    else if (MAX_CYCLES != 0 && cycle_cnt + 32'd1 == 32'(MAX_CYCLES))
      cause_nxt = CAUSE_WATCHDOG;
    else
      trigger = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rstn) begin
      state       <= ST_RUN;
      retired_cnt <= '0;
      cycle_cnt   <= '0;
      halted      <= 1'b0;
      halt_cause  <= CAUSE_NONE;
      overflow    <= 1'b0;
    end else begin
      case (state)
        ST_RUN: begin
          cycle_cnt <= cycle_cnt + 32'd1;
          if (wb_valid) retired_cnt <= retired_cnt + 32'd1;
          if (push && fifo_full && !pop) overflow <= 1'b1;
          if (trigger) begin
            state      <= ST_DRAIN;
            halt_cause <= cause_nxt;
          end
        end
        ST_DRAIN: begin
          if (drain_done) begin
            state  <= ST_DONE;
            halted <= 1'b1;
          end
        end
        ST_DONE: ;
        default: state <= ST_RUN;
      endcase
    end
  end

  commit_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH ($bits(commit_rec_t))
  ) u_fifo (
    .clk       (clk),
    .rstn      (rstn),
    .push      (push),
    .push_data (rec),
    .pop       (pop),
    .head      (head),
    .empty     (fifo_empty),
    .full      (fifo_full),
    .count     (fifo_count)
  );

  assign trace_pc    = head.pc;
  assign trace_rd    = head.rd;
  assign trace_wdata = head.wdata;

endmodule

// File: tb/tb_wb_commit_monitor.sv
// Scoreboard bench for wb_commit_monitor: expected records are queued as
// retirements are driven and compared when the sink handshakes them out.
module tb_wb_commit_monitor;

  logic        clk = 1'b0;
  logic        rstn = 1'b1;
  logic        wb_valid = 1'b0;
  logic [31:0] wb_pc = '0;
  logic [31:0] wb_instr = '0;
  logic        wb_regwrite = 1'b0;
  logic [4:0]  wb_rd = '0;
  logic [31:0] wb_wdata = '0;
  logic        trace_ready = 1'b0;
  logic        trace_valid;
  logic [31:0] trace_pc;
  logic [4:0]  trace_rd;
  logic [31:0] trace_wdata;
  logic [31:0] retired_cnt;
  logic [31:0] cycle_cnt;
  logic        halted;
  logic [1:0]  halt_cause;
  logic        overflow;

  typedef struct {
    logic [31:0] pc;
    logic [4:0]  rd;
    logic [31:0] wdata;
  } exp_t;

  exp_t        sb[$];
  int          checks = 0;
  int          failures = 0;
  int          pops = 0;
  logic [31:0] tb_cyc;
  bit          model_run = 1'b0;

  wb_commit_monitor dut (
    .clk         (clk),
    .rstn        (rstn),
    .wb_valid    (wb_valid),
    .wb_pc       (wb_pc),
    .wb_instr    (wb_instr),
    .wb_regwrite (wb_regwrite),
    .wb_rd       (wb_rd),
    .wb_wdata    (wb_wdata),
    .trace_valid (trace_valid),
    .trace_ready (trace_ready),
    .trace_pc    (trace_pc),
    .trace_rd    (trace_rd),
    .trace_wdata (trace_wdata),
    .retired_cnt (retired_cnt),
    .cycle_cnt   (cycle_cnt),
    .halted      (halted),
    .halt_cause  (halt_cause),
    .overflow    (overflow)
  );

  always #5 clk = ~clk;

  // Reference count of RUN cycles, stopped by the stimulus after a halt trigger.
  always @(posedge clk) begin
    if (rstn) tb_cyc <= '0;
    else if (model_run) tb_cyc <= tb_cyc + 32'd1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Handshake monitor: inputs change #1 after posedge, so negedge sees what the next edge samples.
  always @(negedge clk) begin
    exp_t e;
    if (!rstn && trace_valid && trace_ready) begin
      if (sb.size() == 0) begin
        check("spurious_pop", 32'd1, 32'd0);
      end else begin
        e = sb.pop_front();
        check("rec_pc", trace_pc, e.pc);
        check("rec_rd", 32'(trace_rd), 32'(e.rd));
        check("rec_wdata", trace_wdata, e.wdata);
        pops++;
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic retire(input logic [31:0] pc, input logic [31:0] instr, input logic rw,
                        input logic [4:0] rd, input logic [31:0] wd, input bit expect_push);
    exp_t e;
    wb_valid = 1'b1;
    wb_pc = pc;
    wb_instr = instr;
    wb_regwrite = rw;
    wb_rd = rd;
    wb_wdata = wd;
    if (expect_push) begin
      e.pc = pc;
      e.rd = (rw && rd != 5'd0) ? rd : 5'd0;
      e.wdata = (rw && rd != 5'd0) ? wd : 32'd0;
      sb.push_back(e);
    end
    @(posedge clk);
    #1;
    wb_valid = 1'b0;
  endtask

  task automatic do_reset();
    rstn = 1'b1;
    wb_valid = 1'b0;
    model_run = 1'b0;
    @(posedge clk);
    #1;
    sb.delete();
    pops = 0;
    check("rst_trace_valid", 32'(trace_valid), 32'd0);
    check("rst_trace_pc", trace_pc, 32'd0);
    check("rst_trace_rd", 32'(trace_rd), 32'd0);
    check("rst_trace_wdata", trace_wdata, 32'd0);
    check("rst_retired", retired_cnt, 32'd0);
    check("rst_cycle", cycle_cnt, 32'd0);
    check("rst_halted", 32'(halted), 32'd0);
    check("rst_cause", 32'(halt_cause), 32'd0);
    check("rst_overflow", 32'(overflow), 32'd0);
    rstn = 1'b0;
    model_run = 1'b1;
    @(posedge clk);
    #1;
    check("first_cycle_cnt", cycle_cnt, 32'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "simulation time limit");
  end

  initial begin
    // In-order retirements with the sink always ready.
    do_reset();
    trace_ready = 1'b1;
    retire(32'h0, 32'h13, 1'b1, 5'd5, 32'd7, 1'b1);
    check("push_latency", 32'(trace_valid), 32'd1);
    retire(32'h4, 32'h13, 1'b1, 5'd5, 32'd7, 1'b1);
    retire(32'h8, 32'h13, 1'b1, 5'd5, 32'd7, 1'b1);
    idle(2);
    check("t1_pops", 32'(pops), 32'd3);
    check("t1_retired", retired_cnt, 32'd3);
    check("t1_cycle", cycle_cnt, tb_cyc);
    check("t1_sb_empty", 32'(sb.size()), 32'd0);

    // END_PC halt, then later retirements are ignored.
    retire(32'h50, 32'h13, 1'b1, 5'd6, 32'd9, 1'b1);
    model_run = 1'b0;
    check("t2_cause", 32'(halt_cause), 32'd1);
    check("t2_halted_early", 32'(halted), 32'd0);
    idle(1);
    check("t2_halted", 32'(halted), 32'd1);
    check("t2_pops", 32'(pops), 32'd4);
    for (int i = 0; i < 3; i++) retire(32'h60 + 32'(4 * i), 32'h13, 1'b1, 5'd3, 32'd3, 1'b0);
    idle(1);
    check("t2_retired_frozen", retired_cnt, 32'd4);
    check("t2_cycle_frozen", cycle_cnt, tb_cyc);
    check("t2_no_trace", 32'(trace_valid), 32'd0);
    check("t2_still_halted", 32'(halted), 32'd1);

    // END_PC outranks the self-loop encoding.
    do_reset();
    trace_ready = 1'b1;
    retire(32'h50, 32'h0000_006f, 1'b0, 5'd0, 32'd0, 1'b1);
    check("t3_cause", 32'(halt_cause), 32'd1);
    idle(1);
    check("t3_halted", 32'(halted), 32'd1);
    check("t3_retired", retired_cnt, 32'd1);

    // Watchdog with no retirements.
    do_reset();
    trace_ready = 1'b1;
    for (int i = 0; i < 60 && cycle_cnt != 32'd40; i++) idle(1);
    check("wd_reach40", cycle_cnt, 32'd40);
    check("wd_halted_early", 32'(halted), 32'd0);
    idle(1);
    check("wd_halted", 32'(halted), 32'd1);
    check("wd_cause", 32'(halt_cause), 32'd3);
    idle(3);
    check("wd_cycle_stop", cycle_cnt, 32'd40);
    check("wd_retired", retired_cnt, 32'd0);

    // Overflow: nine retirements into eight slots with the sink stalled.
    do_reset();
    trace_ready = 1'b0;
    for (int i = 0; i < 9; i++)
      retire(32'h100 + 32'(4 * i), 32'h13, (i % 3) != 2, (i == 4) ? 5'd0 : 5'(i + 1),
             32'hA0 + 32'(i), i < 8);
    check("ovf_flag", 32'(overflow), 32'd1);
    check("ovf_retired", retired_cnt, 32'd9);
    check("ovf_valid", 32'(trace_valid), 32'd1);
    check("ovf_head_pc", trace_pc, 32'h100);
    idle(1);
    check("ovf_head_stable", trace_pc, 32'h100);
    trace_ready = 1'b1;
    idle(12);
    check("ovf_pops", 32'(pops), 32'd8);
    check("ovf_sb_empty", 32'(sb.size()), 32'd0);
    check("ovf_drained", 32'(trace_valid), 32'd0);
    check("ovf_sticky", 32'(overflow), 32'd1);

    // Reset in the middle of DRAIN with four records buffered.
    do_reset();
    trace_ready = 1'b0;
    for (int i = 0; i < 3; i++) retire(32'h200 + 32'(4 * i), 32'h13, 1'b1, 5'd2, 32'd11, 1'b1);
    retire(32'h50, 32'h13, 1'b1, 5'd2, 32'd12, 1'b1);
    idle(2);
    check("t6_draining", 32'(trace_valid), 32'd1);
    check("t6_not_halted", 32'(halted), 32'd0);
    check("t6_cause", 32'(halt_cause), 32'd1);
    do_reset();
    retire(32'h300, 32'h13, 1'b1, 5'd9, 32'h55, 1'b1);
    check("t6_run_valid", 32'(trace_valid), 32'd1);
    check("t6_run_retired", retired_cnt, 32'd1);
    check("t6_run_cycle", cycle_cnt, tb_cyc);
    trace_ready = 1'b1;
    idle(2);
    check("t6_pops", 32'(pops), 32'd1);
    check("t6_sb_empty", 32'(sb.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
